// File: rtl/instr_pkg.sv
// -----------------------------------------------------------------------------
// instr_pkg
// Shared definitions for the instruction encoder/loader:
//   - op_sel_e : mnemonic selector seen on the loader input (13-15 illegal)
//   - OPC_*    : 6-bit MIPS primary opcodes
//   - FN_*     : 6-bit MIPS funct codes for the SPECIAL (R-type) opcode
//   - state_e  : loader session states
//   - r_word / i_word / j_word : pack fields into a 32-bit machine word
// -----------------------------------------------------------------------------
package instr_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_JR   = 4'd5,
        OP_ADDI = 4'd6,
        OP_SLTI = 4'd7,
        OP_BEQ  = 4'd8,
        OP_LW   = 4'd9,
        OP_SW   = 4'd10,
        OP_J    = 4'd11,
        OP_JAL  = 4'd12
    } op_sel_e;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_ADDI    = 6'b001000;
    localparam logic [5:0] OPC_SLTI    = 6'b001010;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;
    localparam logic [5:0] OPC_J       = 6'b000010;
    localparam logic [5:0] OPC_JAL     = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ST_PAD is only reachable when the nop-padding option is built in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // R-type layout: opcode | rs | rt | rd | shamt(0) | funct
    function automatic logic [31:0] r_word(input logic [4:0] rs,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd,
                                           input logic [5:0] funct);
        return {OPC_SPECIAL, rs, rt, rd, 5'd0, funct};
    endfunction

    // I-type layout: opcode | rs | rt | imm
    function automatic logic [31:0] i_word(input logic [5:0]  opc,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    // J-type layout: opcode | target
    function automatic logic [31:0] j_word(input logic [5:0]  opc,
                                           input logic [25:0] target);
        return {opc, target};
    endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// -----------------------------------------------------------------------------
// instr_field_encoder
// Purely combinational: turns a mnemonic selector plus raw register/immediate
// fields into a 32-bit MIPS machine word. Fields a format does not use are
// forced to zero so stray bench/boot values never leak into the word.
// Ports:
//   op_sel  in  4   mnemonic selector (op_sel_e values, 13-15 illegal)
//   rs      in  5   source register
//   rt      in  5   target register
//   rd      in  5   destination register
//   imm     in  16  immediate / branch offset (used verbatim)
//   target  in  26  jump target field
//   word    out 32  encoded instruction (0 when illegal)
//   illegal out 1   op_sel is not a supported mnemonic
// -----------------------------------------------------------------------------
module instr_field_encoder
    import instr_pkg::*;
(
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        case (op_sel)
            OP_ADD:  word = r_word(rs, rt, rd, FN_ADD);
            OP_SUB:  word = r_word(rs, rt, rd, FN_SUB);
            OP_AND:  word = r_word(rs, rt, rd, FN_AND);
            OP_OR:   word = r_word(rs, rt, rd, FN_OR);
            OP_SLT:  word = r_word(rs, rt, rd, FN_SLT);
            // JR only names rs; rt and rd are masked off.
            OP_JR:   word = r_word(rs, 5'd0, 5'd0, FN_JR);
            OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
            OP_SLTI: word = i_word(OPC_SLTI, rs, rt, imm);
            OP_BEQ:  word = i_word(OPC_BEQ, rs, rt, imm);
            OP_LW:   word = i_word(OPC_LW, rs, rt, imm);
            OP_SW:   word = i_word(OPC_SW, rs, rt, imm);
            OP_J:    word = j_word(OPC_J, target);
            OP_JAL:  word = j_word(OPC_JAL, target);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Session-based program loader: accepts mnemonic-level beats over a
// valid/ready handshake, encodes each into a MIPS word and writes it to
// consecutive instruction-memory word addresses through a registered write
// port (one cycle after acceptance, full throughput).
//
// Build option: define NOP_PAD_EN to fill the unused tail of memory with
// 32'h00000000 after a session closes early (PAD state). Without it the
// remaining memory is left untouched.
//
// Ports:
//   clk_i        in  1         clock, rising edge
//   rst_i        in  1         asynchronous active-low reset
//   start_i      in  1         begin a session (honoured in IDLE/DONE)
//   valid_i      in  1         beat valid
//   ready_o      out 1         loader can accept a beat
//   last_i       in  1         final beat of the session
//   op_sel_i     in  4         mnemonic selector
//   rs_i/rt_i/rd_i in 5        register fields
//   imm_i        in  16        immediate / branch offset
//   target_i     in  26        jump target
//   mem_we_o     out 1         single-cycle write strobe
//   mem_addr_o   out ADDR_W    word address (holds between writes)
//   mem_wdata_o  out 32        encoded word (holds between writes)
//   count_o      out ADDR_W+1  program words written this session
//   done_o       out 1         level, high while in DONE
//   error_o      out 1         sticky illegal-op flag for this session
// -----------------------------------------------------------------------------
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              last_i,
    input  logic [3:0]        op_sel_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              done_o,
    output logic              error_o
);

    // Pointer is one bit wider than the address so "memory full" (== DEPTH)
    // is simply its top bit.
    localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state;
    state_e              state_next;
    logic [ADDR_W:0]     ptr;
    logic [ADDR_W:0]     count;
    logic                closing;
    logic                error_flag;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;
    logic                ptr_full;
    logic                accept;
    logic                start_load;
    logic                pad_write;
    logic [31:0]         enc_word;
    logic                enc_illegal;

    instr_field_encoder u_encoder (
        .op_sel  (op_sel_i),
        .rs      (rs_i),
        .rt      (rt_i),
        .rd      (rd_i),
        .imm     (imm_i),
        .target  (target_i),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign ptr_full = ptr[ADDR_W];

    // "closing" covers the cycle in which the final word is being written;
    // holding ready low there stops a beat sneaking in after last_i, and
    // leaving LOAD one cycle later makes done_o rise after the final write.
    assign ready_o     = (state == ST_LOAD) && !ptr_full && !closing;
    assign done_o      = (state == ST_DONE);
    assign count_o     = count;
    assign error_o     = error_flag;
    assign mem_we_o    = mem_we;
    assign mem_addr_o  = mem_addr;
    assign mem_wdata_o = mem_wdata;

    // Session state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the per-cycle datapath commands (accept a beat,
    // clear for a new session, emit a pad word).
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        start_load = 1'b0;
        pad_write  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_next = ST_LOAD;
                    start_load = 1'b1;
                end
            end
            ST_LOAD: begin
                accept = valid_i && ready_o;
                if (closing) begin
`ifdef NOP_PAD_EN
                    state_next = ptr_full ? ST_DONE : ST_PAD;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef NOP_PAD_EN
            ST_PAD: begin
                // One extra cycle after the last pad write before DONE so
                // done_o again trails the final write.
                if (ptr_full) begin
                    state_next = ST_DONE;
                end else begin
                    pad_write = 1'b1;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Pointer, counters, sticky error and the registered memory write port.
    // Illegal beats are consumed without touching the pointer, but a last_i
    // on them still closes the session.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr        <= '0;
            count      <= '0;
            closing    <= 1'b0;
            error_flag <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            if (start_load) begin
                ptr        <= '0;
                count      <= '0;
                closing    <= 1'b0;
                error_flag <= 1'b0;
            end else if (accept) begin
                if (enc_illegal) begin
                    error_flag <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr[ADDR_W-1:0];
                    mem_wdata <= enc_word;
                    ptr       <= ptr + PTR_ONE;
                    count     <= count + PTR_ONE;
                end
                closing <= last_i || (!enc_illegal && (ptr == LAST_SLOT));
            end else if (pad_write) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr[ADDR_W-1:0];
                mem_wdata <= 32'd0;
                ptr       <= ptr + PTR_ONE;
            end else if (closing) begin
                closing <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Self-checking bench for instr_encoder_loader (ADDR_W = 2, DEPTH = 4).
// A phase-level model of the load session runs in step with the clock and a
// single compare process checks every DUT output on every falling edge.
// Directed sessions pin the model with hand-encoded words; randomized
// sessions then stress handshake, illegal ops, early last, full memory,
// ignored starts and mid-session resets. Honours NOP_PAD_EN.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef NOP_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_CLOSE = 2;
    localparam int PH_PAD   = 3;
    localparam int PH_DONE  = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          valid_i;
    logic          ready_o;
    logic          last_i;
    logic [3:0]    op_sel_i;
    logic [4:0]    rs_i;
    logic [4:0]    rt_i;
    logic [4:0]    rd_i;
    logic [15:0]   imm_i;
    logic [25:0]   target_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [AW:0]   count_o;
    logic          done_o;
    logic          error_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t wlog[$];

    // Model state
    int          m_phase;
    int          m_ptr;
    int          m_cnt;
    bit          m_err;
    bit          exp_we;
    int          exp_addr;
    logic [31:0] exp_data;

    logic [5:0] fn_tab  [0:4]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] opc_tab [6:12] = '{6'h08, 6'h0A, 6'h04, 6'h23, 6'h2B, 6'h02, 6'h03};

    instr_encoder_loader #(.ADDR_W(AW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .last_i      (last_i),
        .op_sel_i    (op_sel_i),
        .rs_i        (rs_i),
        .rt_i        (rt_i),
        .rd_i        (rd_i),
        .imm_i       (imm_i),
        .target_i    (target_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .count_o     (count_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Reference encoding straight from the MIPS field layouts.
    function automatic logic [31:0] enc_ref(input int op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm, input logic [25:0] tgt);
        if (op <= 4)  return {6'd0, rs, rt, rd, 5'd0, fn_tab[op]};
        if (op == 5)  return {6'd0, rs, 15'd0, 6'h08};
        if (op <= 10) return {opc_tab[op], rs, rt, imm};
        if (op <= 12) return {opc_tab[op], tgt};
        return 32'd0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task model_reset;
        m_phase  = PH_IDLE;
        m_ptr    = 0;
        m_cnt    = 0;
        m_err    = 1'b0;
        exp_we   = 1'b0;
        exp_addr = 0;
        exp_data = 32'd0;
    endtask

    // Advance the model by one rising edge using the inputs presented to it.
    task model_step;
        exp_we = 1'b0;
        if (!rst_i) begin
            model_reset();
            return;
        end
        case (m_phase)
            PH_IDLE, PH_DONE: begin
                if (start_i) begin
                    m_phase = PH_LOAD;
                    m_ptr   = 0;
                    m_cnt   = 0;
                    m_err   = 1'b0;
                end
            end
            PH_LOAD: begin
                if (valid_i && m_ptr < DEPTH) begin
                    if (int'(op_sel_i) > 12) begin
                        m_err = 1'b1;
                    end else begin
                        exp_we   = 1'b1;
                        exp_addr = m_ptr;
                        exp_data = enc_ref(int'(op_sel_i), rs_i, rt_i, rd_i, imm_i, target_i);
                        m_ptr++;
                        m_cnt++;
                    end
                    if (last_i || m_ptr == DEPTH) m_phase = PH_CLOSE;
                end
            end
            PH_CLOSE: m_phase = (PAD_EN && m_ptr < DEPTH) ? PH_PAD : PH_DONE;
            PH_PAD: begin
                if (m_ptr == DEPTH) begin
                    m_phase = PH_DONE;
                end else begin
                    exp_we   = 1'b1;
                    exp_addr = m_ptr;
                    exp_data = 32'd0;
                    m_ptr++;
                end
            end
            default: m_phase = PH_IDLE;
        endcase
    endtask

    // Compare every observable output against the model each cycle.
    always @(negedge clk_i) begin
        checkOutput("ready", 32'(ready_o), 32'(m_phase == PH_LOAD && m_ptr < DEPTH));
        checkOutput("done", 32'(done_o), 32'(m_phase == PH_DONE));
        checkOutput("count", 32'(count_o), 32'(m_cnt));
        checkOutput("error", 32'(error_o), 32'(m_err));
        checkOutput("mem_we", 32'(mem_we_o), 32'(exp_we));
        checkOutput("mem_addr", 32'(mem_addr_o), 32'(exp_addr));
        checkOutput("mem_wdata", mem_wdata_o, exp_data);
        if (mem_we_o) wlog.push_back('{int'(mem_addr_o), mem_wdata_o, cyc});
    end

    task tick;
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task idle(input int n);
        repeat (n) tick();
    endtask

    task startSession;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task applyStimulus(input bit v, input bit l, input int op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic [25:0] tgt);
        valid_i  = v;
        last_i   = l;
        op_sel_i = 4'(op);
        rs_i     = rs;
        rt_i     = rt;
        rd_i     = rd;
        imm_i    = imm;
        target_i = tgt;
        tick();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task pulseReset;
        #1 rst_i = 1'b0;
        model_reset();
        tick();
        #1 rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; valid_i = 1'b0; last_i = 1'b0;
        op_sel_i = 4'd0; rs_i = 5'd0; rt_i = 5'd0; rd_i = 5'd0;
        imm_i = 16'd0; target_i = 26'd0;
        model_reset();
        tick();
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_count", 32'(count_o), 32'd0);
        checkOutput("rst_ready", 32'(ready_o), 32'd0);
        #1 rst_i = 1'b1;

        // Pin the reference encoder with hand-encoded words.
        checkOutput("ref_add",  enc_ref(0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0), 32'h00221820);
        checkOutput("ref_addi", enc_ref(6, 5'd1, 5'd2, 5'd7, 16'd5, 26'd0), 32'h20220005);
        checkOutput("ref_jr",   enc_ref(5, 5'd31, 5'd7, 5'd9, 16'd0, 26'd0), 32'h03E00008);
        checkOutput("ref_jal",  enc_ref(12, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10), 32'h0C000010);

        // Single ADD with last.
        wlog.delete();
        startSession();
        applyStimulus(1, 1, 0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        idle(8);
        checkOutput("t1_nwr", 32'(wlog.size()), PAD_EN ? 32'd4 : 32'd1);
        checkOutput("t1_addr", 32'(wlog[0].addr), 32'd0);
        checkOutput("t1_data", wlog[0].data, 32'h00221820);
        checkOutput("t1_done", 32'(done_o), 32'd1);
        checkOutput("t1_count", 32'(count_o), 32'd1);
        if (PAD_EN) begin
            for (int i = 1; i < 4; i++) begin
                checkOutput("pad_addr", 32'(wlog[i].addr), 32'(i));
                checkOutput("pad_data", wlog[i].data, 32'd0);
            end
        end

        // Back-to-back ADDI, LW, BEQ.
        wlog.delete();
        startSession();
        applyStimulus(1, 0, 6, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0);
        applyStimulus(1, 0, 9, 5'd0, 5'd4, 5'd0, 16'd8, 26'd0);
        applyStimulus(1, 1, 8, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0);
        idle(6);
        checkOutput("t2_d0", wlog[0].data, 32'h20220005);
        checkOutput("t2_d1", wlog[1].data, 32'h8C040008);
        checkOutput("t2_d2", wlog[2].data, 32'h1022FFFF);
        checkOutput("t2_a2", 32'(wlog[2].addr), 32'd2);
        checkOutput("t2_gap", 32'(wlog[2].cyc - wlog[0].cyc), 32'd2);

        // JAL then JR with masked rt/rd.
        wlog.delete();
        startSession();
        applyStimulus(1, 0, 12, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
        applyStimulus(1, 1, 5, 5'd31, 5'd7, 5'd9, 16'd0, 26'd0);
        idle(6);
        checkOutput("t3_jal", wlog[0].data, 32'h0C000010);
        checkOutput("t3_jr", wlog[1].data, 32'h03E00008);

        // Illegal op between two legal beats.
        wlog.delete();
        startSession();
        applyStimulus(1, 0, 0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        applyStimulus(1, 0, 14, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        applyStimulus(1, 1, 1, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
        idle(6);
        checkOutput("t4_err", 32'(error_o), 32'd1);
        checkOutput("t4_a1", 32'(wlog[1].addr), 32'd1);
        checkOutput("t4_d1", wlog[1].data, 32'h00853022);
        checkOutput("t4_count", 32'(count_o), 32'd2);

        // Five beats without last into a four-word memory.
        wlog.delete();
        startSession();
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 0, 6, 5'd1, 5'd2, 5'd0, 16'(i), 26'd0);
        idle(3);
        checkOutput("t5_nwr", 32'(wlog.size()), 32'd4);
        checkOutput("t5_a3", 32'(wlog[3].addr), 32'd3);
        checkOutput("t5_done", 32'(done_o), 32'd1);
        checkOutput("t5_ready", 32'(ready_o), 32'd0);
        checkOutput("t5_count", 32'(count_o), 32'd4);
        checkOutput("t5_err", 32'(error_o), 32'd0);

        // Reset mid-session, then a fresh session restarts at address 0.
        startSession();
        applyStimulus(1, 0, 0, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0);
        pulseReset();
        checkOutput("t6_done", 32'(done_o), 32'd0);
        checkOutput("t6_count", 32'(count_o), 32'd0);
        checkOutput("t6_we", 32'(mem_we_o), 32'd0);
        wlog.delete();
        startSession();
        applyStimulus(1, 1, 9, 5'd0, 5'd4, 5'd0, 16'd8, 26'd0);
        idle(6);
        checkOutput("t6_addr", 32'(wlog[0].addr), 32'd0);
        checkOutput("t6_data", wlog[0].data, 32'h8C040008);

        // Randomized sessions.
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 9) == 0) pulseReset();
            startSession();
            for (int b = 0; b < 10; b++) begin
                int op;
                op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(13, 15))
                                                  : int'($urandom_range(0, 12));
                start_i = ($urandom_range(0, 9) == 0);
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, op,
                              5'($urandom), 5'($urandom), 5'($urandom),
                              16'($urandom), 26'($urandom));
                start_i = 1'b0;
            end
            idle(8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
